// File: rtl/mist32e10fa_dual_port_mem_arbiter_pkg.sv
// mist32e10fa_dual_port_mem_arbiter_pkg: shared types and default sizes for the dual-port memory arbiter
package mist32e10fa_dual_port_mem_arbiter_pkg;
  typedef logic port_id_t;
  localparam port_id_t P0 = 1'b0;
  localparam port_id_t P1 = 1'b1;
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_QD = 8;
endpackage

// File: rtl/mist32e10fa_arbiter_id_fifo.sv
// mist32e10fa_arbiter_id_fifo: in-order queue of issuing port IDs, each with a flashable valid bit
module mist32e10fa_arbiter_id_fifo
  import mist32e10fa_dual_port_mem_arbiter_pkg::*;
#(
  parameter int QD = DEF_QD,
  parameter int QDN = 3
) (
  input  logic     iCLOCK,
  input  logic     inRESET,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  input  logic     flash,
  output port_id_t head_id,
  output logic     head_vld,
  output logic     full,
  output logic     empty
);
  port_id_t ids [QD];
  logic [QD-1:0] vld, vld_nxt;
  logic [QDN-1:0] wp, rp;
  logic [QDN:0] cnt;
  assign full = cnt == (QDN+1)'(QD);
  assign empty = cnt == '0;
  assign head_id = ids[rp];
  assign head_vld = vld[rp];
  // a push in a flash cycle lands after the clear, so it stays valid
  always_comb begin
    vld_nxt = flash ? '0 : vld;
    if (pop) vld_nxt[rp] = 1'b0;
    if (push) vld_nxt[wp] = 1'b1;
  end
  always_ff @(posedge iCLOCK)
    if (push) ids[wp] <= push_id;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (QDN+1)'(push) - (QDN+1)'(pop);
      vld <= vld_nxt;
    end
endmodule

// File: rtl/mist32e10fa_dual_port_mem_arbiter.sv
// mist32e10fa_dual_port_mem_arbiter: two requesters onto one in-order memory port with response routing
// MIST32E10FA_DUAL_PORT_ARB_RR_EN selects round-robin tie resolution instead of fixed P0 priority
module mist32e10fa_dual_port_mem_arbiter
  import mist32e10fa_dual_port_mem_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int QD = DEF_QD,
  parameter int QDN = 3
) (
  input  logic          iCLOCK,
  input  logic          inRESET,
  input  logic          iFLASH,
  input  logic          iP0_REQ,
  output logic          oP0_BUSY,
  input  logic          iP0_RW,
  input  logic [AW-1:0] iP0_ADDR,
  input  logic [DW-1:0] iP0_DATA,
  input  logic          iP1_REQ,
  output logic          oP1_BUSY,
  input  logic          iP1_RW,
  input  logic [AW-1:0] iP1_ADDR,
  input  logic [DW-1:0] iP1_DATA,
  output logic          oMEM_REQ,
  input  logic          iMEM_BUSY,
  output logic          oMEM_RW,
  output logic [AW-1:0] oMEM_ADDR,
  output logic [DW-1:0] oMEM_DATA,
  input  logic          iMEM_VALID,
  input  logic [DW-1:0] iMEM_DATA,
  output logic          oP0_VALID,
  output logic [DW-1:0] oP0_DATA,
  output logic          oP1_VALID,
  output logic [DW-1:0] oP1_DATA
);
  state_t state;
  port_id_t head_id;
  logic full, empty, head_vld, pop, acc, g0, g1;
  assign pop = iMEM_VALID && !empty;
  // a response retiring this cycle frees a slot for the request arriving with it
  assign acc = (state == IDLE || !iMEM_BUSY) && (!full || pop);
`ifdef MIST32E10FA_DUAL_PORT_ARB_RR_EN
  port_id_t rr;
  assign g0 = acc && iP0_REQ && (!iP1_REQ || rr == P0);
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) rr <= P0;
    else if (g0 || g1) rr <= g0 ? P1 : P0;
`else
  assign g0 = acc && iP0_REQ;
`endif
  assign g1 = acc && iP1_REQ && !g0;
  assign oP0_BUSY = inRESET && (!acc || g1);
  assign oP1_BUSY = inRESET && (!acc || g0);
  assign oP0_VALID = inRESET && pop && head_vld && !iFLASH && head_id == P0;
  assign oP1_VALID = inRESET && pop && head_vld && !iFLASH && head_id == P1;
  assign oP0_DATA = iMEM_DATA;
  assign oP1_DATA = iMEM_DATA;
  assign oMEM_REQ = state == ISSUE;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      state <= IDLE;
      oMEM_RW <= 1'b0;
      oMEM_ADDR <= '0;
      oMEM_DATA <= '0;
    end else if (g0 || g1) begin
      state <= ISSUE;
      oMEM_RW <= g1 ? iP1_RW : iP0_RW;
      oMEM_ADDR <= g1 ? iP1_ADDR : iP0_ADDR;
      oMEM_DATA <= g1 ? iP1_DATA : iP0_DATA;
    end else if (!iMEM_BUSY) state <= IDLE;
  mist32e10fa_arbiter_id_fifo #(.QD(QD), .QDN(QDN)) u_fifo (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .push(g0 || g1),
    .push_id(g1),
    .pop(pop),
    .flash(iFLASH),
    .head_id(head_id),
    .head_vld(head_vld),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_mist32e10fa_dual_port_mem_arbiter.sv
// tb_mist32e10fa_dual_port_mem_arbiter: directed self-checking bench for the dual-port memory arbiter
`timescale 1ns/1ps
module tb_mist32e10fa_dual_port_mem_arbiter;
`ifdef MIST32E10FA_DUAL_PORT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic iCLOCK = 1'b0, inRESET = 1'b0, iFLASH = 1'b0;
  logic iP0_REQ = 1'b0, iP0_RW = 1'b0, iP1_REQ = 1'b0, iP1_RW = 1'b0;
  logic [31:0] iP0_ADDR = '0, iP0_DATA = '0, iP1_ADDR = '0, iP1_DATA = '0;
  logic iMEM_BUSY = 1'b0, iMEM_VALID = 1'b0;
  logic [31:0] iMEM_DATA = '0;
  logic oP0_BUSY, oP1_BUSY, oMEM_REQ, oMEM_RW, oP0_VALID, oP1_VALID;
  logic [31:0] oMEM_ADDR, oMEM_DATA, oP0_DATA, oP1_DATA;
  int checks = 0, errors = 0;
  always #5 iCLOCK = ~iCLOCK;
  mist32e10fa_dual_port_mem_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLASH(iFLASH),
    .iP0_REQ(iP0_REQ), .oP0_BUSY(oP0_BUSY), .iP0_RW(iP0_RW), .iP0_ADDR(iP0_ADDR), .iP0_DATA(iP0_DATA),
    .iP1_REQ(iP1_REQ), .oP1_BUSY(oP1_BUSY), .iP1_RW(iP1_RW), .iP1_ADDR(iP1_ADDR), .iP1_DATA(iP1_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
    .oP0_VALID(oP0_VALID), .oP0_DATA(oP0_DATA), .oP1_VALID(oP1_VALID), .oP1_DATA(oP1_DATA)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge iCLOCK);
    #1;
  endtask
  task automatic resp(input string tag, input logic e0, input logic e1);
    iMEM_VALID = 1'b1;
    iMEM_DATA = $urandom;
    #1;
    check({tag, "_v0"}, oP0_VALID, e0);
    check({tag, "_v1"}, oP1_VALID, e1);
    check({tag, "_d"}, e1 ? oP1_DATA : oP0_DATA, iMEM_DATA);
    cyc();
    iMEM_VALID = 1'b0;
  endtask
  initial begin
    iP0_REQ = 1'b1;
    iMEM_VALID = 1'b1;
    #12;
    check("rst_req", oMEM_REQ, 0);
    check("rst_rw", oMEM_RW, 0);
    check("rst_addr", oMEM_ADDR, 0);
    check("rst_data", oMEM_DATA, 0);
    check("rst_busy0", oP0_BUSY, 0);
    check("rst_busy1", oP1_BUSY, 0);
    check("rst_v0", oP0_VALID, 0);
    iP0_REQ = 1'b0;
    iMEM_VALID = 1'b0;
    @(negedge iCLOCK);
    inRESET = 1'b1;
    cyc();
    check("empty_resp", oP0_VALID | oP1_VALID, 0);
    // simultaneous requests from both ports
    iP0_REQ = 1'b1; iP0_ADDR = 32'h10;
    iP1_REQ = 1'b1; iP1_ADDR = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_busy0", oP0_BUSY, RR && k[0]);
      check("tie_busy1", oP1_BUSY, !(RR && k[0]));
      cyc();
      check("tie_req", oMEM_REQ, 1);
      check("tie_addr", oMEM_ADDR, (RR && k[0]) ? 32'h20 : 32'h10);
    end
    iP0_REQ = 1'b0; iP1_REQ = 1'b0;
    cyc();
    check("tie_idle", oMEM_REQ, 0);
    for (int k = 0; k < 4; k++) resp("tie_resp", !(RR && k[0]), RR && k[0]);
    resp("tie_drained", 0, 0);
    // single P0 read, response two cycles after accept
    iP0_REQ = 1'b1; iP0_RW = 1'b0; iP0_ADDR = 32'h100;
    #1;
    check("rd_busy0", oP0_BUSY, 0);
    cyc();
    iP0_REQ = 1'b0;
    check("rd_req", oMEM_REQ, 1);
    check("rd_rw", oMEM_RW, 0);
    check("rd_addr", oMEM_ADDR, 32'h100);
    cyc();
    check("rd_idle", oMEM_REQ, 0);
    resp("rd_resp", 1, 0);
    // memory stall holds the command, then back-to-back accept
    iP1_REQ = 1'b1; iP1_RW = 1'b1; iP1_ADDR = 32'h300; iP1_DATA = 32'h55;
    iMEM_BUSY = 1'b1;
    #1;
    check("st_busy1_idle", oP1_BUSY, 0);
    cyc();
    iP1_ADDR = 32'h304; iP1_DATA = 32'h66;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_busy1", oP1_BUSY, 1);
      check("st_addr", oMEM_ADDR, 32'h300);
      check("st_wdata", oMEM_DATA, 32'h55);
      check("st_rw", oMEM_RW, 1);
      cyc();
    end
    check("st_addr_end", oMEM_ADDR, 32'h300);
    iMEM_BUSY = 1'b0;
    #1;
    check("b2b_busy1", oP1_BUSY, 0);
    cyc();
    iP1_REQ = 1'b0;
    check("b2b_req", oMEM_REQ, 1);
    check("b2b_addr", oMEM_ADDR, 32'h304);
    check("b2b_wdata", oMEM_DATA, 32'h66);
    cyc();
    check("b2b_idle", oMEM_REQ, 0);
    resp("st_resp0", 0, 1);
    resp("st_resp1", 0, 1);
    resp("st_resp_none", 0, 0);
    // fill the queue to depth
    iP0_REQ = 1'b1; iP0_RW = 1'b0;
    for (int k = 0; k < 8; k++) begin
      iP0_ADDR = 32'h200 + k;
      #1;
      check("fill_busy0", oP0_BUSY, 0);
      cyc();
      check("fill_addr", oMEM_ADDR, 32'h200 + k);
    end
    iP0_ADDR = 32'h2FF;
    #1;
    check("full_busy0", oP0_BUSY, 1);
    cyc();
    check("full_idle", oMEM_REQ, 0);
    iMEM_VALID = 1'b1;
    #1;
    check("full_pop_busy0", oP0_BUSY, 0);
    check("full_pop_v0", oP0_VALID, 1);
    cyc();
    iMEM_VALID = 1'b0;
    iP0_REQ = 1'b0;
    check("full_pop_addr", oMEM_ADDR, 32'h2FF);
    cyc();
    for (int k = 0; k < 8; k++) resp("full_resp", 1, 0);
    resp("full_drained", 0, 0);
    // flash discards outstanding responses
    iP1_REQ = 1'b1; iP1_RW = 1'b0; iP1_ADDR = 32'h40;
    cyc();
    iP1_REQ = 1'b0; iP0_REQ = 1'b1; iP0_ADDR = 32'h44;
    cyc();
    iP0_REQ = 1'b0; iP1_REQ = 1'b1; iP1_ADDR = 32'h48;
    cyc();
    iP1_REQ = 1'b0;
    check("fl_held", oMEM_ADDR, 32'h48);
    iFLASH = 1'b1;
    cyc();
    iFLASH = 1'b0;
    for (int k = 0; k < 3; k++) resp("fl_resp", 0, 0);
    resp("fl_none", 0, 0);
    iP0_REQ = 1'b1; iP0_ADDR = 32'h50;
    cyc();
    iP0_REQ = 1'b0;
    check("fl_new_addr", oMEM_ADDR, 32'h50);
    cyc();
    resp("fl_new_resp", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
